// File: rtl/tiny_imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tiny_imem_arbiter_pkg
// Brief    : Shared FSM encodings and write-counter constants for the
//            instruction-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tiny_imem_arbiter_pkg;

    localparam int unsigned c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 1'b0;
    localparam logic [c_STATE_W-1:0] c_ST_RESP = 1'b1;

    localparam int unsigned c_WR_CNT_W = 5;
    localparam logic [c_WR_CNT_W-1:0] c_WR_CNT_MAX = 5'd31;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [c_WR_CNT_W-1:0] sat_inc(input logic [c_WR_CNT_W-1:0] value);
        logic [c_WR_CNT_W-1:0] result;
        result = value;
        if (value != c_WR_CNT_MAX) begin
            result = value + {{(c_WR_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tiny_imem_ram.sv
`default_nettype none
// ============================================================================
// Module   : tiny_imem_ram
// Brief    : 2**ADDR_W x DATA_W instruction RAM, one write port and one
//            combinational read port; optional even-parity bit per word
//            enabled by macro IMEM_PARITY_EN. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module tiny_imem_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
`ifdef IMEM_PARITY_EN
    output logic              o_rd_perr,
`endif
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_W;

`ifdef IMEM_PARITY_EN
    // Parity bit lives in the MSB of each stored word.
    logic [DATA_W:0] r_mem [c_DEPTH];
    logic [DATA_W:0] w_rd_word;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= {^i_wr_data, i_wr_data};
        end
    end

    assign w_rd_word = r_mem[i_rd_addr];
    assign o_rd_data = w_rd_word[DATA_W-1:0];
    // Even parity across data plus parity bit reduces to 0 on a clean word.
    assign o_rd_perr = ^w_rd_word;
`else
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
`endif

endmodule
`default_nettype wire

// File: rtl/tiny_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tiny_imem_arbiter
// Brief    : Round-robin arbiter sharing an instruction RAM between a host
//            loader (writes) and a CPU fetch port (reads), with host lock.
//            Optional parity checking enabled by macro IMEM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tiny_imem_arbiter
    import tiny_imem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              lock,
    output logic [4:0]        wr_count,
    output logic              cpu_perr
);

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_state_nxt;
    logic                  r_rr_last;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;
    logic [c_WR_CNT_W-1:0] r_wr_count;
    logic                  w_cpu_elig;
    logic [DATA_W-1:0]     w_ram_rdata;

    assign w_cpu_elig = cpu_req & ~lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (cpu_gnt) w_state_nxt = c_ST_RESP;
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Loader wins unless the CPU is also eligible and the loader was served last.
    always_comb begin
        ld_ready = 1'b0;
        cpu_gnt  = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (ld_valid && (!w_cpu_elig || r_rr_last)) begin
                ld_ready = 1'b1;
            end else if (w_cpu_elig) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_wr_count <= '0;
        end else begin
            r_rvalid <= cpu_gnt;
            if (cpu_gnt) begin
                r_rdata   <= w_ram_rdata;
                r_rr_last <= 1'b1;
            end else if (ld_ready) begin
                r_rr_last  <= 1'b0;
                r_wr_count <= sat_inc(r_wr_count);
            end
        end
    end

    assign cpu_rvalid = r_rvalid;
    assign cpu_rdata  = r_rdata;
    assign wr_count   = r_wr_count;

`ifdef IMEM_PARITY_EN
    logic w_ram_perr;
    logic r_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= cpu_gnt & w_ram_perr;
        end
    end

    assign cpu_perr = r_perr;

    tiny_imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (ld_ready),
        .i_wr_addr (ld_addr),
        .i_wr_data (ld_data),
        .i_rd_addr (cpu_addr),
        .o_rd_perr (w_ram_perr),
        .o_rd_data (w_ram_rdata)
    );
`else
    assign cpu_perr = 1'b0;

    tiny_imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (ld_ready),
        .i_wr_addr (ld_addr),
        .i_wr_data (ld_data),
        .i_rd_addr (cpu_addr),
        .o_rd_data (w_ram_rdata)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_tiny_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiny_imem_arbiter
// Brief    : Directed self-checking bench for tiny_imem_arbiter; parity
//            scenario included when IMEM_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tiny_imem_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              ld_valid = 1'b0;
    logic [ADDR_W-1:0] ld_addr  = '0;
    logic [DATA_W-1:0] ld_data  = '0;
    logic              ld_ready;
    logic              cpu_req  = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              lock     = 1'b0;
    logic [4:0]        wr_count;
    logic              cpu_perr;

    int n_pass  = 0;
    int n_total = 0;

    tiny_imem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .lock       (lock),
        .wr_count   (wr_count),
        .cpu_perr   (cpu_perr)
    );

    always #5 clk = ~clk;

    // Leaves the bench at a falling edge with rst_n just released.
    task automatic do_reset();
        ld_valid = 1'b0; cpu_req = 1'b0; lock = 1'b0;
        ld_addr = '0; ld_data = '0; cpu_addr = '0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 1'b0;
        ld_valid = 1'b0; cpu_req = 1'b0; lock = 1'b0;
        #1;
        n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", cpu_rvalid); else n_pass++;
        n_total++; if (cpu_rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", cpu_rdata); else n_pass++;
        n_total++; if (wr_count !== 5'd0) $display("FAIL rst_wr_count: got %0d want 0", wr_count); else n_pass++;
        n_total++; if (cpu_perr !== 1'b0) $display("FAIL rst_perr: got %b want 0", cpu_perr); else n_pass++;
        n_total++; if (ld_ready !== 1'b0) $display("FAIL rst_ld_ready: got %b want 0", ld_ready); else n_pass++;
        n_total++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt: got %b want 0", cpu_gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL rst_rvalid_clk: got %b want 0", cpu_rvalid); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_write_fetch();
        do_reset();
        ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 8'h41; #1;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL wf_ld_ready: got %b want 1", ld_ready); else n_pass++;
        n_total++; if (cpu_gnt !== 1'b0) $display("FAIL wf_gnt_idle: got %b want 0", cpu_gnt); else n_pass++;
        @(negedge clk); ld_valid = 1'b0; cpu_req = 1'b1; cpu_addr = 4'd3; #1;
        n_total++; if (cpu_gnt !== 1'b1) $display("FAIL wf_cpu_gnt: got %b want 1", cpu_gnt); else n_pass++;
        n_total++; if (wr_count !== 5'd1) $display("FAIL wf_wr_count: got %0d want 1", wr_count); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL wf_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
        n_total++; if (cpu_rdata !== 8'h41) $display("FAIL wf_rdata: got %h want 41", cpu_rdata); else n_pass++;
        n_total++; if (cpu_perr !== 1'b0) $display("FAIL wf_perr: got %b want 0", cpu_perr); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (cpu_gnt !== 1'b0) $display("FAIL wf_gnt_resp: got %b want 0", cpu_gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL wf_rvalid_pulse: got %b want 0", cpu_rvalid); else n_pass++;
        n_total++; if (cpu_rdata !== 8'h41) $display("FAIL wf_rdata_hold: got %h want 41", cpu_rdata); else n_pass++;
        // A write at the edge before a fetch must be visible to that fetch.
        @(negedge clk); cpu_req = 1'b0; ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 8'h99;
        @(negedge clk); ld_valid = 1'b0; cpu_req = 1'b1; cpu_addr = 4'd3;
        @(posedge clk); #1;
        n_total++; if (cpu_rdata !== 8'h99) $display("FAIL wf_rdata_new: got %h want 99", cpu_rdata); else n_pass++;
        @(negedge clk); cpu_req = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_ld;
        logic exp_cpu;
        do_reset();
        ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 8'h55; cpu_req = 1'b1; cpu_addr = 4'd7;
        for (int i = 0; i < 9; i++) begin
            #1;
            exp_ld  = (i % 3 == 0);
            exp_cpu = (i % 3 == 1);
            n_total++; if (ld_ready !== exp_ld) $display("FAIL rr_ld_ready[%0d]: got %b want %b", i, ld_ready, exp_ld); else n_pass++;
            n_total++; if (cpu_gnt !== exp_cpu) $display("FAIL rr_cpu_gnt[%0d]: got %b want %b", i, cpu_gnt, exp_cpu); else n_pass++;
            if (i % 3 == 2) begin
                n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL rr_rvalid[%0d]: got %b want 1", i, cpu_rvalid); else n_pass++;
                n_total++; if (cpu_rdata !== 8'h55) $display("FAIL rr_rdata[%0d]: got %h want 55", i, cpu_rdata); else n_pass++;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0; cpu_req = 1'b0; #1;
        n_total++; if (wr_count !== 5'd3) $display("FAIL rr_wr_count: got %0d want 3", wr_count); else n_pass++;
    endtask

    task automatic test_lock();
        do_reset();
        lock = 1'b1; cpu_req = 1'b1; cpu_addr = 4'd1; ld_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld_addr = ADDR_W'(8 + i);
            ld_data = DATA_W'(8'h10 + i);
            #1;
            n_total++; if (cpu_gnt !== 1'b0) $display("FAIL lock_cpu_gnt[%0d]: got %b want 0", i, cpu_gnt); else n_pass++;
            n_total++; if (ld_ready !== 1'b1) $display("FAIL lock_ld_ready[%0d]: got %b want 1", i, ld_ready); else n_pass++;
            @(negedge clk);
        end
        ld_valid = 1'b0; #1;
        n_total++; if (wr_count !== 5'd10) $display("FAIL lock_wr_count: got %0d want 10", wr_count); else n_pass++;
        n_total++; if (cpu_gnt !== 1'b0) $display("FAIL lock_gnt_idle: got %b want 0", cpu_gnt); else n_pass++;
        @(negedge clk); lock = 1'b0; #1;
        n_total++; if (cpu_gnt !== 1'b1) $display("FAIL unlock_gnt: got %b want 1", cpu_gnt); else n_pass++;
        @(posedge clk); #1;
        // Address 8+9 wrapped to 1 inside four address bits.
        n_total++; if (cpu_rdata !== 8'h19) $display("FAIL lock_wrap_rdata: got %h want 19", cpu_rdata); else n_pass++;
        @(negedge clk); cpu_req = 1'b0;
    endtask

    task automatic test_saturation();
        logic [4:0] exp_cnt;
        do_reset();
        ld_valid = 1'b1; ld_addr = 4'd15;
        for (int i = 0; i < 40; i++) begin
            ld_data = DATA_W'(i);
            @(posedge clk); #1;
            exp_cnt = (i + 1 > 31) ? 5'd31 : 5'(i + 1);
            n_total++; if (wr_count !== exp_cnt) $display("FAIL sat_wr_count[%0d]: got %0d want %0d", i, wr_count, exp_cnt); else n_pass++;
        end
        ld_valid = 1'b0;
        @(posedge clk); #1;
        n_total++; if (wr_count !== 5'd31) $display("FAIL sat_hold: got %0d want 31", wr_count); else n_pass++;
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        ld_valid = 1'b1; ld_addr = 4'd6; ld_data = 8'hA5;
        @(negedge clk); ld_valid = 1'b0; cpu_req = 1'b1; cpu_addr = 4'd6;
        @(posedge clk); #1;
        n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL rr_resp_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
        cpu_req = 1'b0; rst_n = 1'b0; #1;
        n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL rir_rvalid: got %b want 0", cpu_rvalid); else n_pass++;
        n_total++; if (cpu_rdata !== 8'h00) $display("FAIL rir_rdata: got %h want 00", cpu_rdata); else n_pass++;
        n_total++; if (wr_count !== 5'd0) $display("FAIL rir_wr_count: got %0d want 0", wr_count); else n_pass++;
        @(negedge clk); rst_n = 1'b1; cpu_req = 1'b1; cpu_addr = 4'd6; #1;
        n_total++; if (cpu_gnt !== 1'b1) $display("FAIL rir_idle_gnt: got %b want 1", cpu_gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL rir_refetch_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
        n_total++; if (cpu_rdata !== 8'hA5) $display("FAIL rir_ram_kept: got %h want a5", cpu_rdata); else n_pass++;
        @(negedge clk); cpu_req = 1'b0;
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        do_reset();
        ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 8'h3C;
        @(negedge clk); ld_addr = 4'd4;
        @(negedge clk); ld_valid = 1'b0;
        dut.u_ram.r_mem[5][DATA_W] = ~dut.u_ram.r_mem[5][DATA_W];
        cpu_req = 1'b1; cpu_addr = 4'd5;
        @(posedge clk); #1;
        n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL par_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
        n_total++; if (cpu_perr !== 1'b1) $display("FAIL par_perr_bad: got %b want 1", cpu_perr); else n_pass++;
        n_total++; if (cpu_rdata !== 8'h3C) $display("FAIL par_rdata: got %h want 3c", cpu_rdata); else n_pass++;
        @(negedge clk); cpu_addr = 4'd4;
        @(posedge clk); #1;
        n_total++; if (cpu_perr !== 1'b0) $display("FAIL par_perr_pulse: got %b want 0", cpu_perr); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (cpu_rvalid !== 1'b1) $display("FAIL par_rvalid_clean: got %b want 1", cpu_rvalid); else n_pass++;
        n_total++; if (cpu_perr !== 1'b0) $display("FAIL par_perr_clean: got %b want 0", cpu_perr); else n_pass++;
        @(negedge clk); cpu_req = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_fetch();
        test_contention();
        test_lock();
        test_saturation();
        test_reset_in_resp();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tiny_imem_arbiter.md
TINY_IMEM_ARBITER -- requirements
Module: tiny_imem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, default 4, instruction memory address width (depth 2**ADDR_W = 16).
REQ-002 SHALL have parameter: DATA_W, default 8, instruction word width.
REQ-003 SHALL have port: clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ld_valid  input  1  host loader write request.
REQ-006 SHALL have port: ld_addr  input  ADDR_W  loader write address.
REQ-007 SHALL have port: ld_data  input  DATA_W  loader write data.
REQ-008 SHALL have port: ld_ready  output  1  loader write accepted this cycle when high with ld_valid.
REQ-009 SHALL have port: cpu_req  input  1  CPU fetch request.
REQ-010 SHALL have port: cpu_addr  input  ADDR_W  fetch address (PC).
REQ-011 SHALL have port: cpu_gnt  output  1  fetch accepted this cycle when high with cpu_req.
REQ-012 SHALL have port: cpu_rvalid  output  1  fetch data valid, one-cycle pulse.
REQ-013 SHALL have port: cpu_rdata  output  DATA_W  fetched instruction word.
REQ-014 SHALL have port: lock  input  1  host lock; blocks all CPU grants.
REQ-015 SHALL have port: wr_count  output  5  saturating count of accepted loader writes.
REQ-016 SHALL have port: cpu_perr  output  1  parity error flag on fetched word.

Function
REQ-017 SHALL contain a 2**ADDR_W x DATA_W instruction RAM, shared by loader (write-only) and CPU (read-only).
REQ-018 SHALL implement FSM states IDLE and RESP; grants are issued only in IDLE.
REQ-019 SHALL drive ld_ready and cpu_gnt combinationally from state, requests, lock and rr_last; at most one is high per cycle.
REQ-020 SHALL, with only one eligible requester in IDLE, grant that requester.
REQ-021 SHALL, with both eligible in IDLE, grant the requester not served last (1-bit rr_last; reset value 1 = CPU last, so loader wins first contention).
REQ-022 SHALL treat the CPU as ineligible whenever lock=1; the loader is then granted every IDLE cycle.
REQ-023 SHALL, on accepted loader write, write ld_data to RAM[ld_addr] at that edge, set rr_last=0, stay in IDLE (back-to-back writes at one per cycle).
REQ-024 SHALL, on accepted fetch at edge N, register RAM[cpu_addr] into cpu_rdata, set rr_last=1, enter RESP; cpu_rvalid=1 for exactly cycle N+1; return to IDLE at edge N+1.
REQ-025 SHALL hold cpu_rdata stable until the next accepted fetch.
REQ-026 SHALL, in RESP, drive ld_ready=0 and cpu_gnt=0 (max fetch rate one per 2 cycles).
REQ-027 SHALL return pre-write data for a fetch following a write only if the write was accepted at a later edge; a write accepted before the fetch edge is visible to that fetch.
REQ-028 SHALL increment wr_count per accepted write, saturating at 31 (no wrap).
REQ-029 SHALL wrap addresses naturally within ADDR_W bits; no out-of-range condition exists.

Reset
REQ-030 SHALL, on rst_n low (including mid-RESP), asynchronously force state=IDLE, rr_last=1, cpu_rvalid=0, cpu_rdata=0, wr_count=0, cpu_perr=0; in-flight fetch is discarded.
REQ-031 SHALL NOT reset RAM contents.

Configuration
REQ-032 SHALL support macro IMEM_PARITY_EN: when defined, store an even-parity bit per word on write, recheck on fetch, drive cpu_perr registered alongside cpu_rvalid (valid only in that cycle).
REQ-033 SHALL, without IMEM_PARITY_EN, store no parity bit and tie cpu_perr to 0.

Structure
REQ-034 SHALL place FSM state encodings (IDLE, RESP) and the wr_count width/saturation constant in the shared CPU package.
REQ-035 SHALL implement the RAM (with optional parity bit) as sub-module tiny_imem_ram; arbitration/FSM stays in tiny_imem_arbiter.

Verification
REQ-036 SHALL cover: writes 0x41 to addr 3, then cpu_req addr 3 -> cpu_gnt next IDLE cycle, cpu_rvalid one cycle later, cpu_rdata=0x41.
REQ-037 SHALL cover: ld_valid and cpu_req both held from reset -> grants ld, cpu, ld, cpu... (CPU grants separated by RESP cycle).
REQ-038 SHALL cover: lock=1 with cpu_req=1 for 10 cycles -> cpu_gnt=0 throughout; 10 loader writes accepted; wr_count=10.
REQ-039 SHALL cover: 40 accepted writes -> wr_count=31 and holds.
REQ-040 SHALL cover: rst_n pulsed low in RESP cycle -> cpu_rvalid=0 immediately, state IDLE, prior RAM data still readable after reset.
REQ-041 SHALL cover (IMEM_PARITY_EN): force stored parity bit flip on addr 5, fetch addr 5 -> cpu_perr=1 with cpu_rvalid; clean word -> cpu_perr=0.
